// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared FSM states, sync byte and error codes for the boot RAM loader
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CHECK
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h5A;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_SUM     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/boot_ram_loader.sv
// boot_ram_loader: framed byte stream to little-endian word writes into the CPU boot memory
module boot_ram_loader
    import boot_loader_pkg::*;
#(
    parameter int addr_width     = 10,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  we_o,
    output logic [addr_width-1:0] waddr_o,
    output logic [data_width-1:0] wdata_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    localparam int CW = $clog2(timeout_cycles + 1);

    state_t                  state, state_next;
    logic [7:0]              len_lo;
    logic [addr_width:0]     word_count;
    logic [addr_width:0]     word_idx;
    logic [1:0]              byte_idx;
    logic [7:0]              sum;
    logic [data_width-9:0]   lanes;
    logic [CW-1:0]           idle_cnt;
    logic [15:0]             count;
    logic                    len_bad;
    logic                    timed_out;
    logic                    wr;
    logic                    ok;
    logic                    fail;
    logic                    hold_next;
    logic [1:0]              code_next;

    // Count field from the two length bytes; word index is one bit wider so a full-memory image fits
    assign count     = {byte_i, len_lo};
    assign len_bad   = (count == 16'd0) || ({16'd0, count} > 32'(1 << addr_width));
    assign timed_out = (state != IDLE) && !byte_valid_i && (idle_cnt == CW'(timeout_cycles - 1));

    // State register
    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_next;
    end

    // Next state and the one-cycle decisions that feed the registered outputs
    always_comb begin
        state_next = state;
        wr         = 1'b0;
        ok         = 1'b0;
        fail       = 1'b0;
        hold_next  = cpu_hold_o;
        code_next  = err_code_o;
        case (state)
            IDLE: if (byte_valid_i && byte_i == SYNC_BYTE) begin
                state_next = LEN_LO;
                hold_next  = 1'b1;
                code_next  = ERR_NONE;
            end
            LEN_LO: if (byte_valid_i) state_next = LEN_HI;
            LEN_HI: if (byte_valid_i) begin
                state_next = len_bad ? IDLE : PAYLOAD;
                fail       = len_bad;
                code_next  = len_bad ? ERR_LEN : code_next;
            end
            PAYLOAD: if (byte_valid_i && byte_idx == 2'd3) begin
                wr         = 1'b1;
                state_next = (word_idx + 1'b1 == word_count) ? CHECK : PAYLOAD;
            end
            CHECK: if (byte_valid_i) begin
                state_next = IDLE;
                ok         = (sum + byte_i) == 8'd0;
                fail       = !ok;
                hold_next  = ok ? 1'b0 : hold_next;
                code_next  = ok ? code_next : ERR_SUM;
            end
            default: state_next = IDLE;
        endcase
        if (timed_out) begin
            state_next = IDLE;
            fail       = 1'b1;
            code_next  = ERR_TIMEOUT;
        end
    end

    // Inter-byte idle counter; a byte arriving on the limit cycle still resets it
    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE || byte_valid_i || timed_out)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

    // Frame datapath: length latch, byte lanes, running checksum and word index
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_lo     <= '0;
            word_count <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            sum        <= '0;
            lanes      <= '0;
        end else if (byte_valid_i) begin
            if (state == LEN_LO)
                len_lo <= byte_i;
            if (state == LEN_HI) begin
                word_count <= (addr_width + 1)'(count);
                word_idx   <= '0;
                byte_idx   <= '0;
                sum        <= '0;
            end
            if (state == PAYLOAD) begin
                lanes    <= {byte_i, lanes[data_width-9:8]};
                sum      <= sum + byte_i;
                byte_idx <= byte_idx + 1'b1;
                word_idx <= (byte_idx == 2'd3) ? word_idx + 1'b1 : word_idx;
            end
        end
    end

    // Registered outputs; write address and data hold their last value between pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            cpu_hold_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            we_o       <= wr;
            done_o     <= ok;
            err_o      <= fail;
            cpu_hold_o <= hold_next;
            err_code_o <= code_next;
            if (wr) begin
                waddr_o <= word_idx[addr_width-1:0];
                wdata_o <= {byte_i, lanes};
            end
        end
    end

endmodule

// File: tb/tb_boot_ram_loader.sv
// tb_boot_ram_loader: randomized frames checked cycle by cycle against a frame-position reference model
module tb_boot_ram_loader;

    localparam int AW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst, bv, we, hold, done, err;
    logic [7:0]    bd;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [1:0]    code;

    always #5 clk = ~clk;

    boot_ram_loader #(.addr_width(AW), .data_width(32), .timeout_cycles(TO)) dut (
        .clk_i(clk), .rst_i(rst), .byte_valid_i(bv), .byte_i(bd),
        .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .cpu_hold_o(hold),
        .done_o(done), .err_o(err), .err_code_o(code)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame and derives outputs from the frame rules
    bit            armed = 0;
    int            pos, idle, n, nlo, k;
    logic [7:0]    sum;
    logic [31:0]   cur;
    logic          e_we, e_done, e_err, e_hold;
    logic [1:0]    e_code;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_data;

    always @(posedge clk) begin
        if (rst) begin
            armed = 1; pos = 0; idle = 0;
            e_we = 0; e_done = 0; e_err = 0; e_hold = 0; e_code = 0; e_addr = 0; e_data = 0;
        end else begin
            e_we = 0; e_done = 0; e_err = 0;
            if (pos == 0) begin
                if (bv && bd == 8'h5A) begin pos = 1; idle = 0; e_hold = 1; e_code = 0; end
            end else if (bv) begin
                idle = 0;
                if (pos == 1) begin
                    nlo = bd; pos = 2;
                end else if (pos == 2) begin
                    n = bd * 256 + nlo;
                    if (n == 0 || n > (1 << AW)) begin e_err = 1; e_code = 1; pos = 0; end
                    else begin pos = 3; sum = 0; end
                end else if (pos - 3 < 4 * n) begin
                    k = pos - 3;
                    cur[8*(k%4) +: 8] = bd;
                    sum += bd;
                    if (k % 4 == 3) begin e_we = 1; e_addr = AW'(k / 4); e_data = cur; end
                    pos++;
                end else begin
                    if (8'(sum + bd) == 8'd0) begin e_done = 1; e_hold = 0; end
                    else begin e_err = 1; e_code = 2; end
                    pos = 0;
                end
            end else begin
                idle++;
                if (idle == TO) begin e_err = 1; e_code = 3; pos = 0; end
            end
        end
    end

    // Per-cycle compare plus a shadow of everything the DUT wrote to memory
    logic [31:0] dut_mem [0:(1<<AW)-1];
    int nwr = 0, ndone = 0, nerr = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("we", we, e_we);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("hold", hold, e_hold);
            chk("err_code", code, e_code);
            chk("waddr", waddr, e_addr);
            chk("wdata", wdata, e_data);
            if (we) begin dut_mem[waddr] = wdata; nwr++; end
            if (done) ndone++;
            if (err) nerr++;
        end
    end

    // Stimulus helpers: every action lands just after the falling edge
    logic [31:0] words [0:(1<<AW)-1];

    task automatic cyc(input logic v, input logic [7:0] b);
        bv = v; bd = b;
        @(negedge clk); #1;
    endtask

    task automatic tx(input logic [7:0] b, input int maxgap);
        repeat ($urandom_range(0, maxgap)) cyc(0, 8'h00);
        cyc(1, b);
    endtask

    task automatic hdr(input int cnt, input int maxgap);
        tx(8'h5A, maxgap);
        tx(8'(cnt), maxgap);
        tx(8'(cnt >> 8), maxgap);
    endtask

    task automatic send_frame(input int nw, input logic [7:0] bad, input int maxgap);
        logic [7:0] s, b;
        s = 0;
        hdr(nw, maxgap);
        for (int i = 0; i < nw; i++)
            for (int j = 0; j < 4; j++) begin
                b = words[i][8*j +: 8];
                s += b;
                tx(b, maxgap);
            end
        tx(8'(-s) + bad, maxgap);
    endtask

    int w0, d0;

    initial begin
        rst = 1; bv = 0; bd = 0;
        repeat (2) @(negedge clk);
        #1 rst = 0;
        chk("reset_hold", hold, 0);
        chk("reset_we", we, 0);
        chk("reset_code", code, 0);
        chk("reset_waddr", waddr, 0);

        // Noise ahead of the sync byte is ignored
        w0 = nwr;
        cyc(1, 8'h00); cyc(1, 8'hFF); cyc(1, 8'h13);
        chk("preamble_hold", hold, 0);
        chk("preamble_writes", nwr, w0);

        // Good two-word frame; the payload sums to 0xB8 so the checksum is 0x48
        words[0] = 32'h11223344; words[1] = 32'hAABBCCDD;
        d0 = ndone;
        cyc(1, 8'h5A);
        chk("sync_hold", hold, 1);
        cyc(1, 8'h02); cyc(1, 8'h00);
        cyc(1, 8'h44); cyc(1, 8'h33); cyc(1, 8'h22); cyc(1, 8'h11);
        chk("word0_we", we, 1);
        cyc(1, 8'hDD); cyc(1, 8'hCC); cyc(1, 8'hBB); cyc(1, 8'hAA);
        cyc(1, 8'h48);
        chk("good_done", done, 1);
        chk("good_hold", hold, 0);
        chk("good_mem0", dut_mem[0], 32'h11223344);
        chk("good_mem1", dut_mem[1], 32'hAABBCCDD);
        chk("good_done_count", ndone, d0 + 1);

        // Same frame, wrong checksum
        w0 = nwr;
        send_frame(2, 8'h01, 0);
        chk("badsum_err", err, 1);
        chk("badsum_code", code, 2);
        chk("badsum_hold", hold, 1);
        chk("badsum_writes", nwr, w0 + 2);

        // Length errors
        w0 = nwr;
        hdr(0, 0);
        chk("len0_code", code, 1);
        hdr(16'h0401, 0);
        chk("len401_code", code, 1);
        cyc(0, 8'h00);
        chk("len_writes", nwr, w0);

        // Full-depth image
        for (int i = 0; i < (1 << AW); i++) words[i] = $urandom;
        words[(1<<AW)-1] = 32'hCAFE5A01;
        send_frame(1 << AW, 8'h00, 0);
        chk("full_done", done, 1);
        chk("full_last", dut_mem[(1<<AW)-1], 32'hCAFE5A01);

        // Timeout after three payload bytes
        w0 = nwr;
        hdr(1, 0);
        cyc(1, 8'h01); cyc(1, 8'h02); cyc(1, 8'h03);
        repeat (TO + 2) cyc(0, 8'h00);
        chk("timeout_code", code, 3);
        chk("timeout_writes", nwr, w0);
        chk("timeout_hold", hold, 1);

        // Fifteen idle cycles then the last byte still completes the word
        hdr(1, 0);
        cyc(1, 8'h01); cyc(1, 8'h02); cyc(1, 8'h03);
        repeat (TO - 1) cyc(0, 8'h00);
        cyc(1, 8'h04);
        chk("stall15_we", we, 1);
        chk("stall15_data", wdata, 32'h04030201);
        cyc(1, 8'hF6);
        chk("stall15_done", done, 1);

        // Sync value inside the payload is plain data
        words[0] = 32'h5A5A5A5A;
        send_frame(1, 8'h00, 1);
        chk("data5a_mem", dut_mem[0], 32'h5A5A5A5A);
        chk("data5a_done", done, 1);

        // Reset in the middle of a payload
        hdr(2, 0);
        cyc(1, 8'h10); cyc(1, 8'h20); cyc(1, 8'h30); cyc(1, 8'h40); cyc(1, 8'h50);
        rst = 1;
        cyc(0, 8'h00);
        rst = 0;
        chk("midrst_hold", hold, 0);
        chk("midrst_wdata", wdata, 0);
        chk("midrst_code", code, 0);
        words[0] = 32'h01234567; words[1] = 32'h89ABCDEF;
        send_frame(2, 8'h00, 2);
        chk("afterrst_done", done, 1);
        chk("afterrst_mem1", dut_mem[1], 32'h89ABCDEF);

        // Randomized frames, noise and stalls, all checked by the model
        for (int f = 0; f < 40; f++) begin
            int nw;
            repeat ($urandom_range(0, 3)) cyc($urandom_range(0, 1), 8'($urandom_range(0, 8'h59)));
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++)
                words[i] = ($urandom_range(0, 4) == 0) ? 32'h5A00005A ^ $urandom_range(0, 255) : $urandom;
            if ($urandom_range(0, 5) == 0) begin
                hdr(nw, 2);
                repeat ($urandom_range(0, 6)) tx(8'($urandom), 2);
                repeat ($urandom_range(TO, TO + 3)) cyc(0, 8'h00);
            end else begin
                send_frame(nw, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 3);
            end
            cyc(0, 8'h00);
        end

        repeat (3) cyc(0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

endmodule
